// File: rtl/pwm_multi_drive.sv
// Multi-channel PWM generator: shared prescaler/period counter, shadowed duty and polarity.
// Optional CENTER_ALIGN_EN adds a center input selecting triangle (center-aligned) counting.
module pwm_multi_drive #(
    parameter int CH = 4,
    parameter int CW = 16,
    parameter int PW = 8
) (
    input  logic            clk,
    input  logic            rsn,
    input  logic            en,
    input  logic [PW-1:0]   prescale,
    input  logic [CW-1:0]   period,
    input  logic [CH*CW-1:0] duty,
    input  logic [CH-1:0]   pol,
    input  logic            upd,
`ifdef CENTER_ALIGN_EN
    input  logic            center,
`endif
    output logic            upd_ack,
    output logic            prd_tick,
    output logic [CH-1:0]   pwm_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q;
    logic [PW-1:0]      pcnt_q;
    logic [PW-1:0]      pre_sh_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      prd_sh_q;
    logic [CH*CW-1:0]   duty_sh_q;
    logic [CH-1:0]      pol_sh_q;
    logic [CH-1:0]      pwm_q;
    logic               pend_q;
    logic               ack_q;
    logic               ptick_q;

    logic               tick;
    logic               bnd;
    logic               load;
    logic [CW-1:0]      cnt_d;
    logic [CH-1:0]      cmp;

`ifdef CENTER_ALIGN_EN
    logic               ctr_sh_q;
    logic               dir_q;
    logic               dir_d;
`endif

    always_comb begin
        tick  = (pcnt_q == pre_sh_q);
        bnd   = 1'b0;
        cnt_d = cnt_q;
`ifdef CENTER_ALIGN_EN
        dir_d = dir_q;
        if (ctr_sh_q) begin
            // End values are held one tick while the direction flips
            bnd = tick && dir_q && (cnt_q == '0);
            if (tick) begin
                if (!dir_q) begin
                    if (cnt_q == prd_sh_q) dir_d = 1'b1;
                    else                   cnt_d = cnt_q + 1'b1;
                end else begin
                    if (cnt_q == '0) dir_d = 1'b0;
                    else             cnt_d = cnt_q - 1'b1;
                end
            end
        end else begin
            bnd   = tick && (cnt_q == prd_sh_q);
            dir_d = 1'b0;
            if (tick) cnt_d = bnd ? '0 : cnt_q + 1'b1;
        end
`else
        bnd = tick && (cnt_q == prd_sh_q);
        if (tick) cnt_d = bnd ? '0 : cnt_q + 1'b1;
`endif
        if (state_q == IDLE) load = en || upd;
        else                 load = en && bnd && (pend_q || upd);
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CH; i++)
            cmp[i] = (cnt_q < duty_sh_q[i*CW +: CW]) ^ pol_sh_q[i];
    end

    always_ff @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            cnt_q     <= '0;
            pre_sh_q  <= '0;
            prd_sh_q  <= '0;
            duty_sh_q <= '0;
            pol_sh_q  <= '0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            ptick_q   <= 1'b0;
            pwm_q     <= '0;
`ifdef CENTER_ALIGN_EN
            ctr_sh_q  <= 1'b0;
            dir_q     <= 1'b0;
`endif
        end else begin
            ack_q  <= load;
            pend_q <= (pend_q || upd) && !load;
            if (load) begin
                pre_sh_q  <= prescale;
                prd_sh_q  <= period;
                duty_sh_q <= duty;
                pol_sh_q  <= pol;
`ifdef CENTER_ALIGN_EN
                ctr_sh_q  <= center;
`endif
            end
            unique case (state_q)
                IDLE: begin
                    pcnt_q  <= '0;
                    cnt_q   <= '0;
                    ptick_q <= 1'b0;
                    pwm_q   <= pol_sh_q;
`ifdef CENTER_ALIGN_EN
                    dir_q   <= 1'b0;
`endif
                    if (en) state_q <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state_q <= IDLE;
                        pcnt_q  <= '0;
                        cnt_q   <= '0;
                        ptick_q <= 1'b0;
                        pwm_q   <= pol_sh_q;
`ifdef CENTER_ALIGN_EN
                        dir_q   <= 1'b0;
`endif
                    end else begin
                        pcnt_q  <= tick ? '0 : pcnt_q + 1'b1;
                        cnt_q   <= cnt_d;
                        ptick_q <= bnd;
                        pwm_q   <= cmp;
`ifdef CENTER_ALIGN_EN
                        dir_q   <= dir_d;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign upd_ack  = ack_q;
    assign prd_tick = ptick_q;
    assign pwm_o    = pwm_q;

endmodule
